bullet_hit_judge: RTL and testbench

//  Downstream of the bullet mover. On every 8 Hz move tick, compares the bullet grid position (24x12, 5-bit coords) against N enemy tanks.
//  On a hit: clears the enemy's alive bit, bumps a saturating score, pulses a hit event, and holds a bullet-kill request until the bullet is retired.

---
 rtl/tank_pkg.sv | 22 ++
 rtl/tick_edge_det.sv | 20 ++
 rtl/bullet_hit_judge.sv | 164 ++++++++++++++++
 tb/tb_bullet_hit_judge.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared playfield geometry and encodings for the tank game blocks
package tank_pkg;

  localparam int GRID_X = 24;
  localparam int GRID_Y = 12;
  localparam int POS_W  = 5;
  localparam logic [POS_W-1:0] POS_PARKED = 5'b11111;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    JUDGE_IDLE   = 2'b00,
    JUDGE_SCAN   = 2'b01,
    JUDGE_REPORT = 2'b10
  } judge_state_t;

endpackage

// File: rtl/tick_edge_det.sv
// rtl/tick_edge_det.sv - rising-edge detector for a slow tick level sampled on clk
module tick_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic enable,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk) begin
    if (rst) level_d <= 1'b0;
    else     level_d <= level;
  end

  // The delayed copy keeps tracking while disabled, so re-enabling never fakes an edge.
  assign rise = level & ~level_d & enable;

endmodule

// File: rtl/bullet_hit_judge.sv
// rtl/bullet_hit_judge.sv - per-tick bullet vs enemy collision scan, kill mask and score
module bullet_hit_judge
  import tank_pkg::*;
#(
  parameter int N_ENEMY     = 4,
  parameter int SCORE_W     = 8,
  parameter int GRID_X      = tank_pkg::GRID_X,
  parameter int GRID_Y      = tank_pkg::GRID_Y,
  parameter int CLR_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       clk_8Hz,
  input  logic                       bul_state,
  input  logic [POS_W-1:0]           bul_x,
  input  logic [POS_W-1:0]           bul_y,
  input  logic [POS_W*N_ENEMY-1:0]   enemy_xpos,
  input  logic [POS_W*N_ENEMY-1:0]   enemy_ypos,
  input  logic                       respawn,
  output logic [N_ENEMY-1:0]         enemy_alive,
  output logic                       hit_pulse,
  output logic [2:0]                 hit_idx,
  output logic                       bul_clear,
  output logic [SCORE_W-1:0]         score,
  output logic                       all_clear
);

  localparam int CNT_W = $clog2(CLR_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_TIMEOUT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(N_ENEMY - 1);
  localparam logic [POS_W-1:0] X_LIM    = POS_W'(GRID_X);
  localparam logic [POS_W-1:0] Y_LIM    = POS_W'(GRID_Y);

  judge_state_t state, state_next;

  logic             tick_rise;
  logic             start_scan;
  logic             do_scan;
  logic             do_report;
  logic [2:0]       idx;
  logic             snap_state;
  logic [POS_W-1:0] snap_x;
  logic [POS_W-1:0] snap_y;
  logic             matched;
  logic [2:0]       match_idx;
  logic [CNT_W-1:0] clr_cnt;
  logic [POS_W-1:0] cur_x;
  logic [POS_W-1:0] cur_y;
  logic             cur_alive;
  logic             cand;
  logic [N_ENEMY-1:0] kill_mask;

  tick_edge_det u_tick (
    .clk    (clk),
    .rst    (rst),
    .level  (clk_8Hz),
    .enable (enable),
    .rise   (tick_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= JUDGE_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_scan = 1'b0;
    case (state)
      JUDGE_IDLE: begin
        if (tick_rise && !bul_clear) begin
          state_next = JUDGE_SCAN;
          start_scan = 1'b1;
        end
      end
      JUDGE_SCAN:   if (idx == LAST_IDX) state_next = JUDGE_REPORT;
      JUDGE_REPORT: state_next = JUDGE_IDLE;
      default:      state_next = JUDGE_IDLE;
    endcase
    // Respawn and a paused game both abandon any scan in progress.
    if (respawn || !enable) begin
      state_next = JUDGE_IDLE;
      start_scan = 1'b0;
    end
  end

  assign do_scan   = (state == JUDGE_SCAN) && enable && !respawn;
  assign do_report = (state == JUDGE_REPORT) && enable && !respawn && matched;

  // Index mux written as a loop so idx never selects past the packed buses.
  always_comb begin
    cur_x     = '0;
    cur_y     = '0;
    cur_alive = 1'b0;
    kill_mask = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      if (idx == 3'(i)) begin
        cur_x     = enemy_xpos[POS_W*i +: POS_W];
        cur_y     = enemy_ypos[POS_W*i +: POS_W];
        cur_alive = enemy_alive[i];
      end
      kill_mask[i] = (match_idx == 3'(i));
    end
  end

  assign cand = snap_state && (snap_x < X_LIM) && (snap_y < Y_LIM) && cur_alive &&
                (cur_x == snap_x) && (cur_y == snap_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      snap_state  <= 1'b0;
      snap_x      <= '0;
      snap_y      <= '0;
      matched     <= 1'b0;
      match_idx   <= '0;
      enemy_alive <= '1;
      hit_pulse   <= 1'b0;
      hit_idx     <= '0;
      bul_clear   <= 1'b0;
      clr_cnt     <= '0;
      score       <= '0;
      all_clear   <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      all_clear <= (enemy_alive == '0);

      if (start_scan) begin
        snap_state <= bul_state;
        snap_x     <= bul_x;
        snap_y     <= bul_y;
        matched    <= 1'b0;
        idx        <= '0;
      end else if (do_scan) begin
        // First (lowest) match wins; later overlaps are ignored.
        if (cand && !matched) begin
          matched   <= 1'b1;
          match_idx <= idx;
        end
        idx <= idx + 3'd1;
      end

      if (respawn) enemy_alive <= '1;
      else if (do_report) enemy_alive <= enemy_alive & ~kill_mask;

      if (do_report) begin
        if (score != '1) score <= score + 1'b1;
        hit_idx   <= match_idx;
        hit_pulse <= 1'b1;
        bul_clear <= 1'b1;
        clr_cnt   <= '0;
      end else if (bul_clear && enable) begin
        if (!bul_state || clr_cnt == CLR_LAST) begin
          bul_clear <= 1'b0;
          clr_cnt   <= '0;
        end else begin
          clr_cnt <= clr_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bullet_hit_judge.sv
// tb/tb_bullet_hit_judge.sv - table-driven and scoreboard checks for bullet_hit_judge
module tb_bullet_hit_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clk_8Hz;
  logic        bul_state;
  logic [4:0]  bul_x;
  logic [4:0]  bul_y;
  logic [19:0] enemy_xpos;
  logic [19:0] enemy_ypos;
  logic        respawn;
  logic [3:0]  enemy_alive;
  logic        hit_pulse;
  logic [2:0]  hit_idx;
  logic        bul_clear;
  logic [1:0]  score;
  logic        all_clear;

  always #5 clk = ~clk;

  bullet_hit_judge #(
    .N_ENEMY     (4),
    .SCORE_W     (2),
    .GRID_X      (24),
    .GRID_Y      (12),
    .CLR_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clk_8Hz     (clk_8Hz),
    .bul_state   (bul_state),
    .bul_x       (bul_x),
    .bul_y       (bul_y),
    .enemy_xpos  (enemy_xpos),
    .enemy_ypos  (enemy_ypos),
    .respawn     (respawn),
    .enemy_alive (enemy_alive),
    .hit_pulse   (hit_pulse),
    .hit_idx     (hit_idx),
    .bul_clear   (bul_clear),
    .score       (score),
    .all_clear   (all_clear)
  );

  typedef struct {
    logic [2:0] idx;
    logic [3:0] alive;
    logic [1:0] score;
  } exp_t;

  typedef struct {
    logic        bs;
    logic [4:0]  bx;
    logic [4:0]  by;
    logic [19:0] ex;
    logic [19:0] ey;
    logic        hit;
    logic [2:0]  idx;
    logic [1:0]  hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   failures = 0;
  logic [3:0] m_alive = 4'hf;
  logic [1:0] m_score = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] pk(input logic [4:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (hit_pulse === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_hit: got hit_idx %0d expected no hit", hit_idx);
      end else begin
        e = sb.pop_front();
        check("sb_hit_idx", hit_idx, e.idx);
        check("sb_alive", enemy_alive, e.alive);
        check("sb_score", score, e.score);
      end
    end
  end

  task automatic push_hit(input logic [2:0] idx);
    m_alive[idx[1:0]] = 1'b0;
    if (m_score != 2'd3) m_score = m_score + 2'd1;
    sb.push_back('{idx, m_alive, m_score});
  endtask

  task automatic retire(input logic [1:0] hold, input logic hit);
    int n;
    n = 0;
    if (!hit) begin
      bul_state = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("no_clear", bul_clear, 1'b0);
      return;
    end
    check("clear_set", bul_clear, 1'b1);
    case (hold)
      2'd1: begin
        repeat (3) @(negedge clk);
        check("clear_held", bul_clear, 1'b1);
        bul_state = 1'b0;
        @(negedge clk);
        check("clear_drop_late", bul_clear, 1'b0);
      end
      2'd2: begin
        for (int k = 0; k < 40 && bul_clear; k++) begin
          n++;
          @(negedge clk);
        end
        check("clear_timeout_len", n, 16);
        bul_state = 1'b0;
      end
      default: begin
        bul_state = 1'b0;
        @(negedge clk);
        check("clear_drop", bul_clear, 1'b0);
      end
    endcase
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    bul_state  = v.bs;
    bul_x      = v.bx;
    bul_y      = v.by;
    enemy_xpos = v.ex;
    enemy_ypos = v.ey;
    clk_8Hz    = 1'b1;
    if (v.hit) push_hit(v.idx);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) clk_8Hz = 1'b0;
      if (k == 5) check("latency_early", hit_pulse, 1'b0);
    end
    check("hit_at_e6", hit_pulse, v.hit);
    retire(v.hold, v.hit);
    check("all_clear", all_clear, m_alive == 4'h0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  5'd3,  pk(0, 10, 5, 20),  pk(0, 10, 3, 11), 1'b1, 3'd2, 2'd1};
    vecs[1] = '{1'b1, 5'd7,  5'd7,  pk(0, 7, 5, 7),    pk(0, 7, 3, 7),   1'b1, 3'd1, 2'd2};
    vecs[2] = '{1'b0, 5'd7,  5'd7,  pk(0, 7, 5, 7),    pk(0, 7, 3, 7),   1'b0, 3'd0, 2'd0};
    vecs[3] = '{1'b1, 5'd31, 5'd31, pk(31, 7, 5, 7),   pk(31, 7, 3, 7),  1'b0, 3'd0, 2'd0};
    vecs[4] = '{1'b1, 5'd24, 5'd0,  pk(24, 7, 5, 20),  pk(0, 7, 3, 11),  1'b0, 3'd0, 2'd0};
    vecs[5] = '{1'b1, 5'd0,  5'd12, pk(0, 7, 5, 20),   pk(12, 7, 3, 11), 1'b0, 3'd0, 2'd0};
    vecs[6] = '{1'b1, 5'd7,  5'd7,  pk(0, 7, 5, 7),    pk(0, 7, 3, 7),   1'b1, 3'd3, 2'd0};
    vecs[7] = '{1'b1, 5'd23, 5'd11, pk(23, 7, 5, 7),   pk(11, 7, 3, 7),  1'b1, 3'd0, 2'd0};
    vecs[8] = '{1'b1, 5'd23, 5'd11, pk(23, 7, 5, 7),   pk(11, 7, 3, 7),  1'b0, 3'd0, 2'd0};

    rst = 1'b1; enable = 1'b1; clk_8Hz = 1'b0; bul_state = 1'b0; respawn = 1'b0;
    bul_x = 5'd31; bul_y = 5'd31; enemy_xpos = '1; enemy_ypos = '1;
    repeat (2) @(negedge clk);
    check("rst_alive", enemy_alive, 4'hf);
    check("rst_hit", hit_pulse, 1'b0);
    check("rst_idx", hit_idx, 3'd0);
    check("rst_clear", bul_clear, 1'b0);
    check("rst_score", score, 2'd0);
    check("rst_all_clear", all_clear, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply(vecs[i]);

    @(negedge clk);
    respawn = 1'b1;
    @(negedge clk);
    respawn = 1'b0;
    m_alive = 4'hf;
    check("respawn_alive", enemy_alive, 4'hf);
    check("respawn_all_clear_lag", all_clear, 1'b1);
    check("respawn_score", score, 2'd3);
    @(negedge clk);
    check("respawn_all_clear", all_clear, 1'b0);

    enable = 1'b0;
    bul_state = 1'b1; bul_x = 5'd5; bul_y = 5'd3;
    enemy_xpos = pk(0, 10, 5, 20); enemy_ypos = pk(0, 10, 3, 11);
    clk_8Hz = 1'b1;
    repeat (2) @(negedge clk);
    clk_8Hz = 1'b0;
    repeat (6) @(negedge clk);
    check("disabled_alive", enemy_alive, 4'hf);
    enable = 1'b1;
    @(negedge clk);

    clk_8Hz = 1'b1;
    push_hit(3'd2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) clk_8Hz = 1'b0;
    end
    check("busy_first_hit", hit_pulse, 1'b1);
    enemy_xpos = pk(5, 10, 5, 20); enemy_ypos = pk(3, 10, 3, 11);
    clk_8Hz = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_tick_ignored", enemy_alive, 4'b1011);
    check("busy_clear_held", bul_clear, 1'b1);
    bul_state = 1'b0; clk_8Hz = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_clear_drop", bul_clear, 1'b0);

    bul_state = 1'b1; bul_x = 5'd10; bul_y = 5'd10;
    enemy_xpos = pk(0, 10, 5, 20); enemy_ypos = pk(0, 10, 3, 11);
    clk_8Hz = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; clk_8Hz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midscan_rst_alive", enemy_alive, 4'hf);
    check("midscan_rst_hit", hit_pulse, 1'b0);
    check("midscan_rst_idx", hit_idx, 3'd0);
    check("midscan_rst_clear", bul_clear, 1'b0);
    check("midscan_rst_score", score, 2'd0);
    check("midscan_rst_all_clear", all_clear, 1'b0);
    repeat (8) @(negedge clk);
    check("midscan_rst_no_late_hit", enemy_alive, 4'hf);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
